// File: rtl/sram_fifo_128x8_pkg.sv
// sram_fifo_pkg: geometry shared by the SRAM-backed FIFO, its buffer and its interface
package sram_fifo_pkg;
  localparam int DEPTH = 128;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 7;
  localparam int OBUF_DEPTH = 2;
  localparam int CNT_W = ADDR_W + 1;
endpackage

// File: rtl/sram_fifo_128x8_if.sv
// sram_fifo_128x8_if: producer/consumer valid-ready streams plus occupancy
interface sram_fifo_128x8_if;
  import sram_fifo_pkg::*;
  logic enq_valid;
  logic enq_ready;
  logic [DATA_W-1:0] enq_bits;
  logic deq_valid;
  logic deq_ready;
  logic [DATA_W-1:0] deq_bits;
  logic [CNT_W-1:0] count;
  modport master (output enq_valid, enq_bits, deq_ready, input enq_ready, deq_valid, deq_bits, count);
  modport slave (input enq_valid, enq_bits, deq_ready, output enq_ready, deq_valid, deq_bits, count);
endinterface

// File: rtl/SRAM2RW128x8.sv
// SRAM2RW128x8: behavioural dual-port macro; both ports' writes land on CE1, so CE1 and CE2 must share a clock
module SRAM2RW128x8 (
  input  logic       CE1,
  input  logic       CE2,
  input  logic       WEB1,
  input  logic       WEB2,
  input  logic       OEB1,
  input  logic       OEB2,
  input  logic       CSB1,
  input  logic       CSB2,
  input  logic [6:0] A1,
  input  logic [6:0] A2,
  input  logic [7:0] I1,
  input  logic [7:0] I2,
  output logic [7:0] O1,
  output logic [7:0] O2
);
  logic [7:0] mem [128];
  logic [7:0] r1, r2;
  always_ff @(posedge CE1) begin
    if (!CSB1 && !WEB1) mem[A1] <= I1;
    if (!CSB2 && !WEB2) mem[A2] <= I2;
    if (!CSB1 && WEB1) r1 <= mem[A1];
  end
  always_ff @(posedge CE2)
    if (!CSB2 && WEB2) r2 <= mem[A2];
  assign O1 = OEB1 ? '0 : r1;
  assign O2 = OEB2 ? '0 : r2;
endmodule

// File: rtl/sram_fifo_128x8_obuf.sv
// sram_fifo_obuf: 2-entry circular buffer absorbing the macro's read latency
module sram_fifo_obuf
  import sram_fifo_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [1:0]        cnt
);
  logic [DATA_W-1:0] mem [OBUF_DEPTH];
  logic head;
  logic tail;
  assign tail = head ^ cnt[0];
  assign valid = cnt != 2'd0;
  assign data = mem[head];
  always_ff @(posedge clk)
    if (rst) begin
      mem <= '{default: '0};
      head <= 1'b0;
      cnt <= 2'd0;
    end else begin
      if (push) mem[tail] <= push_data;
      head <= head ^ pop;
      cnt <= cnt + 2'(push) - 2'(pop);
    end
endmodule

// File: rtl/sram_fifo_128x8.sv
// sram_fifo_128x8: 128x8 FIFO using macro port 1 for writes, port 2 for reads, and a 2-entry output buffer
module sram_fifo_128x8
  import sram_fifo_pkg::*;
(
  input  logic clock,
  input  logic reset,
  sram_fifo_128x8_if.slave io
);
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] sram_cnt, count_q;
  logic [1:0] obuf_cnt;
  logic [DATA_W-1:0] o1, o2;
  logic rd_inflight, enq_fire, deq_fire, rd_issue, unused_o1;
  assign io.enq_ready = count_q != CNT_W'(DEPTH);
  assign io.count = count_q;
  assign enq_fire = io.enq_valid && io.enq_ready && !reset;
  assign deq_fire = io.deq_valid && io.deq_ready;
  // only read what the buffer can still hold once in-flight data lands
  assign rd_issue = !reset && sram_cnt != '0 &&
                    ({1'b0, obuf_cnt} + 3'(rd_inflight) - 3'(deq_fire)) < 3'(OBUF_DEPTH);
  assign unused_o1 = ^o1;
  always_ff @(posedge clock)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      sram_cnt <= '0;
      count_q <= '0;
      rd_inflight <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + ADDR_W'(enq_fire);
      rd_ptr <= rd_ptr + ADDR_W'(rd_issue);
      sram_cnt <= sram_cnt + CNT_W'(enq_fire) - CNT_W'(rd_issue);
      count_q <= count_q + CNT_W'(enq_fire) - CNT_W'(deq_fire);
      rd_inflight <= rd_issue;
    end
  SRAM2RW128x8 u_sram (
    .CE1(clock), .CE2(clock),
    .WEB1(1'b0), .WEB2(1'b1),
    .OEB1(1'b1), .OEB2(1'b0),
    .CSB1(~enq_fire), .CSB2(~rd_issue),
    .A1(wr_ptr), .A2(rd_ptr),
    .I1(io.enq_bits), .I2('0),
    .O1(o1), .O2(o2)
  );
  sram_fifo_obuf u_obuf (
    .clk(clock), .rst(reset),
    .push(rd_inflight), .push_data(o2), .pop(deq_fire),
    .valid(io.deq_valid), .data(io.deq_bits), .cnt(obuf_cnt)
  );
endmodule

// File: tb/tb_sram_fifo_128x8.sv
// tb_sram_fifo_128x8: directed checks of latency, ordering, full/empty, wrap and mid-run reset
module tb_sram_fifo_128x8;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  int deqs = 0;
  int maxc, minc, d0;
  logic [7:0] q[$];
  sram_fifo_128x8_if io();
  sram_fifo_128x8 dut (.clock(clock), .reset(reset), .io(io));
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // one clock of traffic, checked against a queue model of the contents
  task automatic cyc();
    logic ef, df;
    chk("enq_ready", io.enq_ready, q.size() != 128);
    ef = io.enq_valid && io.enq_ready;
    df = io.deq_valid && io.deq_ready;
    if (df) begin
      deqs++;
      if (q.size() == 0) chk("deq_on_empty", io.deq_valid, 0);
      else chk("deq_bits", io.deq_bits, q.pop_front());
    end
    if (ef) q.push_back(io.enq_bits);
    @(posedge clock); #1;
    chk("count", io.count, q.size());
    if (io.count > maxc) maxc = io.count;
    if (io.count < minc) minc = io.count;
  endtask
  task automatic drain(input string tag);
    io.enq_valid = 1'b0;
    io.deq_ready = 1'b1;
    for (int i = 0; i < 140 && q.size() != 0; i++) cyc();
    chk(tag, q.size(), 0);
  endtask
  initial begin
    io.enq_valid = 1'b0;
    io.enq_bits = '0;
    io.deq_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    chk("rst_enq_ready", io.enq_ready, 1);
    chk("rst_deq_valid", io.deq_valid, 0);
    chk("rst_deq_bits", io.deq_bits, 0);
    chk("rst_count", io.count, 0);
    io.enq_valid = 1'b1;
    io.enq_bits = 8'hA5;
    cyc();
    io.enq_valid = 1'b0;
    chk("lat_c1_dv", io.deq_valid, 0);
    cyc();
    chk("lat_c2_dv", io.deq_valid, 0);
    cyc();
    chk("lat_c3_dv", io.deq_valid, 1);
    chk("lat_c3_bits", io.deq_bits, 8'hA5);
    chk("lat_c3_count", io.count, 1);
    io.deq_ready = 1'b1;
    cyc();
    chk("lat_empty_dv", io.deq_valid, 0);
    maxc = 0;
    d0 = deqs;
    io.enq_valid = 1'b1;
    for (int i = 0; i < 128; i++) begin
      io.enq_bits = 8'(i);
      cyc();
    end
    chk("stream_tput", deqs - d0, 125);
    drain("stream_drained");
    chk("stream_max_le3", maxc <= 3, 1);
    io.deq_ready = 1'b0;
    io.enq_valid = 1'b1;
    for (int i = 0; i < 128; i++) begin
      io.enq_bits = 8'(i);
      cyc();
    end
    chk("full_ready", io.enq_ready, 0);
    chk("full_count", io.count, 128);
    io.enq_bits = 8'hFF;
    cyc();
    chk("full_129th", io.count, 128);
    chk("full_head", io.deq_bits, 8'h00);
    drain("full_drained");
    io.deq_ready = 1'b0;
    io.enq_valid = 1'b1;
    for (int i = 0; i < 128; i++) begin
      io.enq_bits = 8'(i) ^ 8'h5A;
      cyc();
    end
    io.deq_ready = 1'b1;
    maxc = 0;
    minc = 255;
    d0 = deqs;
    repeat (300) begin
      io.enq_bits = 8'($urandom);
      cyc();
    end
    chk("sus_min", minc >= 127, 1);
    chk("sus_max", maxc <= 128, 1);
    chk("sus_tput", deqs - d0, 300);
    drain("sus_drained");
    repeat (10000) begin
      io.enq_valid = 1'($urandom_range(0, 1));
      io.deq_ready = 1'($urandom_range(0, 1));
      io.enq_bits = 8'($urandom);
      cyc();
    end
    drain("rand_drained");
    io.deq_ready = 1'b0;
    io.enq_valid = 1'b1;
    repeat (61) begin
      io.enq_bits = 8'($urandom);
      cyc();
    end
    io.enq_valid = 1'b0;
    io.deq_ready = 1'b1;
    cyc();
    chk("pre_rst_count", io.count, 60);
    reset = 1'b1;
    io.deq_ready = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    q.delete();
    chk("midrst_count", io.count, 0);
    chk("midrst_dv", io.deq_valid, 0);
    chk("midrst_ready", io.enq_ready, 1);
    cyc();
    chk("midrst_no_capture", io.deq_valid, 0);
    io.enq_valid = 1'b1;
    io.enq_bits = 8'h3C;
    cyc();
    io.enq_valid = 1'b0;
    for (int i = 0; i < 6 && !io.deq_valid; i++) cyc();
    chk("fresh_dv", io.deq_valid, 1);
    chk("fresh_bits", io.deq_bits, 8'h3C);
    drain("fresh_drained");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sram_fifo_128x8.md
# sram_fifo_128x8

Synchronous 128-entry × 8-bit FIFO built on the SRAM2RW128x8 dual-port macro. It sits directly upstream of that macro, driving port 1 as a dedicated write port and port 2 as a dedicated read port. A 2-entry output buffer hides the macro's 1-cycle read latency and sustains one enqueue and one dequeue per cycle. Producer and consumer see plain valid/ready streams and never touch macro pins.

## Interface
Parameters:
- DEPTH, 128: SRAM entries. Fixed by the macro; not overridable.
- DATA_W, 8: entry width. Fixed by the macro.
- ADDR_W, 7: log2(DEPTH).
- OBUF_DEPTH, 2: output buffer entries.

Ports:
- clock  in  1  sole clock; also drives macro CE1 and CE2.
- reset  in  1  synchronous, active-high.
- enq_valid  in  1  producer has data.
- enq_ready  out  1  FIFO can accept.
- enq_bits  in  DATA_W  enqueue data.
- deq_valid  out  1  head entry available.
- deq_ready  in  1  consumer takes head.
- deq_bits  out  DATA_W  head entry data.
- count  out  8  total occupancy, 0..128 (SRAM + in-flight + buffer).

## Operation
- Enqueue fires on enq_valid && enq_ready. Dequeue fires on deq_valid && deq_ready.
- enq_ready = (count != 128). This is combinational from registered count and does not depend on deq_ready in the same cycle.
- Write port (port 1):
  - CSB1 = ~enq_fire, WEB1 = 0, OEB1 = 1, A1 = wr_ptr, I1 = enq_bits.
  - wr_ptr increments on enq_fire and wraps 127 -> 0.
- Read port (port 2):
  - WEB2 = 1, OEB2 = 0, A2 = rd_ptr, CSB2 = ~rd_issue.
  - rd_ptr increments on rd_issue and wraps 127 -> 0.
- sram_cnt (0..128) counts entries written but not yet read. It is +1 on enq_fire and -1 on rd_issue.
- rd_issue = (sram_cnt != 0) && (obuf_cnt + rd_inflight - deq_fire < OBUF_DEPTH).
  - rd_inflight is a register equal to the previous cycle's rd_issue.
- Reading only entries counted in sram_cnt guarantees the read address never equals the address written in the same cycle. The macro's same-address read-during-write behaviour is therefore never exercised.
- When rd_inflight = 1, O2 is pushed into the output buffer at the clock edge.
- Output buffer: 2-entry circular buffer.
  - deq_valid = (obuf_cnt != 0); deq_bits = head entry.
  - Push and pop in the same cycle are both honoured.
- count: +1 on enq_fire, -1 on deq_fire, unchanged when both fire.

## Timing
- Reset values: enq_ready = 1, deq_valid = 0, deq_bits = 0, count = 0.
  - Internally: wr_ptr = rd_ptr = 0, sram_cnt = 0, obuf_cnt = 0, rd_inflight = 0.
  - While reset is high, CSB1 = CSB2 = 1.
- Latency from enqueue into an empty FIFO to deq_valid is 3 cycles:
  - E0: enq_fire; write occurs at this edge.
  - Cycle 1: rd_issue.
  - Cycle 2: O2 captured into the buffer.
  - Cycle 3: deq_valid = 1.
- Throughput is 1/cycle in steady state with deq_ready held high.
- Full (count = 128): enq_ready = 0, so no enqueue can fire. A dequeue in that cycle drops count to 127 and enq_ready rises next cycle.
- Empty: deq_valid = 0. enq_ready stays 1.
- Reset asserted mid-operation:
  - All state clears on that edge.
  - An in-flight read is discarded; its O2 is not captured.
  - SRAM contents are not cleared and are unobservable afterwards.
- Pointer wrap is seamless: entry 128 is written at address 0 once that slot has been read.

## Structure
- Shared package sram_fifo_pkg holds DEPTH, DATA_W, ADDR_W, OBUF_DEPTH, and the count width (ADDR_W+1).
- Sub-module sram_fifo_obuf implements the 2-entry output buffer:
  - Inputs: push, push_data, pop.
  - Outputs: valid, data, cnt.
- SRAM2RW128x8 is instantiated as a leaf macro, with CE1 = CE2 = clock.

## Test plan
- Reset, then single enqueue of 0xA5 at cycle 0 -> deq_valid rises at cycle 3 with deq_bits = 0xA5; count = 1 from cycle 1 until dequeue.
- Stream 0x00..0x7F with enq_valid and deq_ready both held high -> output order is identical, with one dequeue per cycle after the 3-cycle fill; count never exceeds 3.
- Enqueue 128 entries with deq_ready = 0 -> enq_ready = 0 and count = 128. A 129th enqueue attempt is not accepted. Drain returns 0x00..0x7F in order.
- Fill to 128, then hold enq_valid = 1 and deq_ready = 1 for 300 cycles -> count stays 127–128, pointers wrap at least twice, and no data is lost or duplicated (scoreboard check).
- Randomly toggle enq_valid and deq_ready for 10k cycles -> scoreboard matches and count equals the model at every cycle.
- Assert reset at count = 60 while a read is in flight -> next cycle count = 0 and deq_valid = 0. A fresh enqueue of 0x3C returns 0x3C, not stale data.
